quick_uart_tx: RTL

Parameterized UART transmitter that serializes parallel words from a valid/ready stream onto a single line, LSB first. It takes its framing from the same parameters as the receive path (`CLK_FREQ`, `BAUD`, `DIV`, `IDLE_VALUE`, `START_BITS`, `DATA_BITS`, `STOP_BITS`), so a matched pair of blocks interoperates. A one-entry holding register accepts the next word while the current frame is on the wire, which gives gapless back-to-back frames.

---
 rtl/quick_uart_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/quick_uart_tx.sv
// UART transmitter: valid/ready words in, LSB-first framed serial line out.
// A one-entry holding register queues the next word so frames run back to back.
module quick_uart_tx #(
   parameter int   CLK_FREQ   = 100000000,
   parameter int   BAUD       = 115200,
   parameter int   DIV        = CLK_FREQ / BAUD,
   parameter logic IDLE_VALUE = 1'b1,
   parameter int   START_BITS = 1,
   parameter int   DATA_BITS  = 8,
   parameter int   STOP_BITS  = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 busy_o,
   output logic                 tx_o
);
   localparam int TOTAL_BITS = START_BITS + DATA_BITS + STOP_BITS;
   localparam int TW = $clog2(DIV) + 1;
   localparam int CW = $clog2(TOTAL_BITS) + 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(TOTAL_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SENDING = 2'd1
   } state_t;

   state_t                 state_q, state_d;
   logic [DATA_BITS-1:0]   hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic [TOTAL_BITS-1:0]  shift_q, shift_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   tx_q, tx_d;
   logic                   load;
   logic [TOTAL_BITS-1:0]  frame_w;

   // Bit 0 of the frame is the first start bit; the shifter moves toward bit 0.
   assign frame_w = {{STOP_BITS{IDLE_VALUE}}, hold_q, {START_BITS{~IDLE_VALUE}}};

   assign ready_o = !hold_full_q && !rst_i;
   assign busy_o  = (state_q == S_SENDING) || hold_full_q;
   assign tx_o    = tx_q;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      timer_d     = timer_q;
      cnt_d       = cnt_q;
      tx_d        = tx_q;
      load        = 1'b0;

      if (valid_i && ready_o) begin
         hold_d      = data_i;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d = IDLE_VALUE;
            if (hold_full_q) load = 1'b1;
         end
         S_SENDING: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TW'(1);
            end else if (cnt_q != '0) begin
               shift_d = {IDLE_VALUE, shift_q[TOTAL_BITS-1:1]};
               tx_d    = shift_q[1];
               cnt_d   = cnt_q - CW'(1);
               timer_d = TIMER_LAST;
            end else if (hold_full_q) begin
               load = 1'b1;
            end else begin
               state_d = S_IDLE;
               tx_d    = IDLE_VALUE;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = IDLE_VALUE;
         end
      endcase

      // Never coincides with acceptance: ready_o is low while hold_full_q is set.
      if (load) begin
         shift_d     = frame_w;
         tx_d        = frame_w[0];
         timer_d     = TIMER_LAST;
         cnt_d       = CNT_LAST;
         hold_full_d = 1'b0;
         state_d     = S_SENDING;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         timer_q     <= '0;
         cnt_q       <= '0;
         tx_q        <= IDLE_VALUE;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         timer_q     <= timer_d;
         cnt_q       <= cnt_d;
         tx_q        <= tx_d;
      end
   end
endmodule
